// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the WISC EX/MEM pipeline boundary.
//   - WISC opcode constants (OP_ADD .. OP_HLT)
//   - stage state encoding (ST_RUN, ST_HALTED)
//   - default datapath / register-address widths
//   - helper functions classifying opcodes for writeback and flag updates
package ex_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } stage_state_t;

  // Opcodes that write the register file: everything in 0000-1011 except
  // SW, plus PCS (which writes the return address).
  function automatic logic writes_reg(input logic [3:0] op);
    return ((op <= OP_LHB) && (op != OP_SW)) || (op == OP_PCS);
  endfunction

  // ADD/SUB update all of Z/V/N.
  function automatic logic updates_zvn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // XOR and the shifts update Z only.
  function automatic logic updates_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// ex_mem_stage_flag_reg: architectural Z/V/N flag register.
// Ports:
//   clk, rst_n        clock, async active-low reset (flags clear to 0)
//   en                a real instruction is being captured this edge
//   opcode            opcode of that instruction
//   result            ALU result (Z from ==0, N from MSB)
//   ovf               signed overflow from the ADD/SUB adder
//   flag_z/v/n        registered flags
// Flags hold whenever en=0 or the opcode does not touch them.
module ex_mem_stage_flag_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovf,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic result_zero;
  assign result_zero = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (en) begin
      if (updates_zvn(opcode)) begin
        flag_z <= result_zero;
        flag_v <= ovf;
        flag_n <= result[DATA_W-1];
      end else if (updates_z_only(opcode)) begin
        flag_z <= result_zero;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline boundary of the WISC 16-bit CPU.
// Registers the EX result and control into the MEM stage, owns the Z/V/N
// flag register and tracks HLT so the core stops cleanly.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall                 hold all stage state (MEM not ready)
//   flush                 squash the instruction being captured
//   ex_valid              EX holds a real instruction
//   ex_opcode/result/ovf/store_data/rd   EX-stage instruction fields
//   mem_valid             MEM holds a real instruction
//   mem_opcode/result/store_data/rd      captured fields
//   mem_reg_we/rd_en/wr_en               decoded writeback / LW / SW strobes
//   flag_z/v/n            architectural flags
//   halted                HLT reached MEM (also the visible FSM state)
//
// Transfer rule: an instruction moves from EX into MEM on a clock edge
// exactly when ex_valid=1, stall=0, flush=0 and the stage is RUNning.
// stall freezes everything (flush is ignored under stall); any other
// non-capturing edge inserts a bubble (mem_valid and strobes cleared,
// data fields hold).
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovf,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic [3:0]        mem_opcode,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_we,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              halted
);

  stage_state_t state, state_next;
  logic         capture;

  assign capture = !stall && !flush && ex_valid && (state == ST_RUN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (!stall) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (capture && (ex_opcode == OP_HLT)) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;  // only reset leaves HALTED
      default:   state_next = ST_RUN;
    endcase
  end

  assign halted = (state == ST_HALTED);

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_we     <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
    end else if (!stall) begin
      if (capture) begin
        mem_valid      <= 1'b1;
        mem_opcode     <= ex_opcode;
        mem_result     <= ex_result;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
        mem_reg_we     <= writes_reg(ex_opcode);
        mem_rd_en      <= (ex_opcode == OP_LW);
        mem_wr_en      <= (ex_opcode == OP_SW);
      end else begin
        // Bubble: flush, ex_valid=0, or halted. Data fields keep old values.
        mem_valid  <= 1'b0;
        mem_reg_we <= 1'b0;
        mem_rd_en  <= 1'b0;
        mem_wr_en  <= 1'b0;
      end
    end
  end

  // ---------------- flags ----------------
  ex_mem_stage_flag_reg #(
    .DATA_W(DATA_W)
  ) u_flag_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (capture),
    .opcode (ex_opcode),
    .result (ex_result),
    .ovf    (ex_ovf),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovf;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [15:0] mem_result;
  logic [15:0] mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_reg_we;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        halted;

  int total  = 0;
  int passed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_result      (ex_result),
    .ex_ovf         (ex_ovf),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .mem_valid      (mem_valid),
    .mem_opcode     (mem_opcode),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_we     (mem_reg_we),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .flag_z         (flag_z),
    .flag_v         (flag_v),
    .flag_n         (flag_n),
    .halted         (halted)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ovf, input logic [15:0] sd, input logic [3:0] rd);
    ex_valid      = v;
    ex_opcode     = op;
    ex_result     = res;
    ex_ovf        = ovf;
    ex_store_data = sd;
    ex_rd         = rd;
  endtask

  // Advance one active edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom),
            16'($urandom), 4'($urandom));
      step();
    end
    total++;
    if ({mem_valid, mem_opcode, mem_result, mem_store_data, mem_rd, mem_reg_we,
         mem_rd_en, mem_wr_en, flag_z, flag_v, flag_n, halted} !== '0)
      $display("FAIL reset_outputs got valid=%b op=%h res=%h sd=%h rd=%h we=%b rd_en=%b wr_en=%b zvn=%b%b%b halted=%b exp all 0",
               mem_valid, mem_opcode, mem_result, mem_store_data, mem_rd, mem_reg_we,
               mem_rd_en, mem_wr_en, flag_z, flag_v, flag_n, halted);
    else passed++;
  endtask

  task automatic test_add_ovf();
    // Release reset away from the edge; the next edge captures the ADD.
    rst_n = 1'b1;
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 16'h1234, 4'h5);
    step();
    total++; if (mem_result !== 16'h8000) $display("FAIL add_result got %h exp 8000", mem_result); else passed++;
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) $display("FAIL add_flags got zvn=%b%b%b exp 011", flag_z, flag_v, flag_n); else passed++;
    total++; if ({mem_valid, mem_reg_we, mem_rd_en, mem_wr_en} !== 4'b1100) $display("FAIL add_ctrl got %b exp 1100", {mem_valid, mem_reg_we, mem_rd_en, mem_wr_en}); else passed++;
    total++; if (mem_rd !== 4'h5) $display("FAIL add_rd got %h exp 5", mem_rd); else passed++;
  endtask

  task automatic test_selective_flags();
    drive(1'b1, 4'h1, 16'h0000, 1'b0, 16'h0, 4'h1);  // SUB -> zero
    step();
    total++; if ({flag_z, flag_v, flag_n} !== 3'b100) $display("FAIL sub_flags got zvn=%b%b%b exp 100", flag_z, flag_v, flag_n); else passed++;
    drive(1'b1, 4'h2, 16'h8001, 1'b1, 16'h0, 4'h2);  // XOR: only Z moves
    step();
    total++; if ({flag_z, flag_v, flag_n} !== 3'b000) $display("FAIL xor_flags got zvn=%b%b%b exp 000", flag_z, flag_v, flag_n); else passed++;
    drive(1'b1, 4'h5, 16'h0000, 1'b1, 16'h0, 4'h2);  // SRA zero result: Z only
    step();
    total++; if ({flag_z, flag_v, flag_n} !== 3'b100) $display("FAIL sra_flags got zvn=%b%b%b exp 100", flag_z, flag_v, flag_n); else passed++;
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 16'h0, 4'h3);  // ADD -> 011
    step();
    drive(1'b1, 4'h7, 16'h0000, 1'b0, 16'h0, 4'h4);  // PADDSB: no flag change
    step();
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) $display("FAIL paddsb_flags got zvn=%b%b%b exp 011", flag_z, flag_v, flag_n); else passed++;
    total++; if (mem_result !== 16'h0000 || mem_reg_we !== 1'b1) $display("FAIL paddsb_capture got res=%h we=%b exp 0000 1", mem_result, mem_reg_we); else passed++;
    drive(1'b1, 4'h3, 16'h0000, 1'b1, 16'h0, 4'h4);  // RED: no flag change
    step();
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) $display("FAIL red_flags got zvn=%b%b%b exp 011", flag_z, flag_v, flag_n); else passed++;
    drive(1'b1, 4'hE, 16'h0000, 1'b0, 16'h0, 4'hF);  // PCS writes reg, no flags
    step();
    total++; if ({mem_reg_we, flag_z, flag_v, flag_n} !== 4'b1011) $display("FAIL pcs got we,zvn=%b exp 1011", {mem_reg_we, flag_z, flag_v, flag_n}); else passed++;
    drive(1'b1, 4'hC, 16'h0000, 1'b0, 16'h0, 4'h0);  // branch: no reg write
    step();
    total++; if ({mem_valid, mem_reg_we} !== 2'b10) $display("FAIL branch_we got valid,we=%b exp 10", {mem_valid, mem_reg_we}); else passed++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 4'h8, 16'h0100, 1'b0, 16'h0, 4'h3);  // LW
    step();
    total++; if ({mem_valid, mem_reg_we, mem_rd_en, mem_wr_en} !== 4'b1110) $display("FAIL lw_ctrl got %b exp 1110", {mem_valid, mem_reg_we, mem_rd_en, mem_wr_en}); else passed++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 16'h0000, 1'b1, 16'hAAAA, 4'h9);
      step();
      total++;
      if ({mem_valid, mem_opcode, mem_result, mem_rd, mem_rd_en, flag_z, flag_v, flag_n} !== {1'b1, 4'h8, 16'h0100, 4'h3, 1'b1, 3'b011})
        $display("FAIL stall_hold[%0d] got v=%b op=%h res=%h rd=%h rd_en=%b zvn=%b%b%b exp 1 8 0100 3 1 011",
                 i, mem_valid, mem_opcode, mem_result, mem_rd, mem_rd_en, flag_z, flag_v, flag_n);
      else passed++;
    end
    flush = 1'b1;  // stall wins over flush
    step();
    total++; if ({mem_valid, mem_rd_en, mem_result} !== {1'b1, 1'b1, 16'h0100}) $display("FAIL stall_flush got v=%b rd_en=%b res=%h exp 1 1 0100", mem_valid, mem_rd_en, mem_result); else passed++;
    stall = 1'b0;  // flush alone with ADD
    step();
    total++; if ({mem_valid, mem_reg_we, mem_rd_en, mem_wr_en} !== 4'b0000) $display("FAIL flush_ctrl got %b exp 0000", {mem_valid, mem_reg_we, mem_rd_en, mem_wr_en}); else passed++;
    total++; if ({flag_z, flag_v, flag_n} !== 3'b011) $display("FAIL flush_flags got zvn=%b%b%b exp 011", flag_z, flag_v, flag_n); else passed++;
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 16'h0, 4'h1);  // bubble via ex_valid=0
    step();
    total++; if ({mem_valid, mem_reg_we, flag_z, flag_v, flag_n} !== 5'b00011) $display("FAIL bubble got %b exp 00011", {mem_valid, mem_reg_we, flag_z, flag_v, flag_n}); else passed++;
  endtask

  task automatic test_sw();
    drive(1'b1, 4'h9, 16'h0040, 1'b0, 16'hBEEF, 4'h6);
    step();
    total++; if ({mem_valid, mem_reg_we, mem_rd_en, mem_wr_en} !== 4'b1001) $display("FAIL sw_ctrl got %b exp 1001", {mem_valid, mem_reg_we, mem_rd_en, mem_wr_en}); else passed++;
    total++; if ({mem_result, mem_store_data} !== {16'h0040, 16'hBEEF}) $display("FAIL sw_data got res=%h sd=%h exp 0040 beef", mem_result, mem_store_data); else passed++;
  endtask

  task automatic test_halt();
    drive(1'b1, 4'hF, 16'h0000, 1'b0, 16'h0, 4'h0);
    step();
    total++; if ({halted, mem_valid, mem_opcode, mem_reg_we} !== {1'b1, 1'b1, 4'hF, 1'b0}) $display("FAIL hlt_capture got halted=%b v=%b op=%h we=%b exp 1 1 f 0", halted, mem_valid, mem_opcode, mem_reg_we); else passed++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'h0, 16'h0000, 1'b0, 16'h0, 4'h7);
      step();
      total++;
      if ({halted, mem_valid, mem_reg_we, flag_z, flag_v, flag_n} !== 6'b100011)
        $display("FAIL halted_ignore[%0d] got halted,v,we,zvn=%b exp 100011", i, {halted, mem_valid, mem_reg_we, flag_z, flag_v, flag_n});
      else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({halted, mem_valid, flag_v, flag_n} !== 4'b0000) $display("FAIL halt_async_reset got %b exp 0000", {halted, mem_valid, flag_v, flag_n}); else passed++;
    step();
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 16'h0, 4'h0);
    step();
    total++; if (halted !== 1'b0) $display("FAIL halt_after_reset got %b exp 0", halted); else passed++;
  endtask

  task automatic test_flush_stall_hlt();
    flush = 1'b1;
    drive(1'b1, 4'hF, 16'h0000, 1'b0, 16'h0, 4'h0);
    step();
    total++; if ({halted, mem_valid} !== 2'b00) $display("FAIL flushed_hlt got halted,v=%b exp 00", {halted, mem_valid}); else passed++;
    flush = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if ({halted, mem_valid} !== 2'b00) $display("FAIL stalled_hlt[%0d] got halted,v=%b exp 00", i, {halted, mem_valid}); else passed++;
    end
    stall = 1'b0;
    step();
    total++; if ({halted, mem_valid, mem_opcode} !== {1'b1, 1'b1, 4'hF}) $display("FAIL released_hlt got halted=%b v=%b op=%h exp 1 1 f", halted, mem_valid, mem_opcode); else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_ovf();
    test_selective_flags();
    test_stall_flush();
    test_sw();
    test_halt();
    test_flush_stall_hlt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
